// File: rtl/rps_pkg.sv
// Shared definitions for the rock/paper/scissors match logic.
//   seq_state_t   : round_sequencer state encoding
//   CHOICE_*      : player/computer choice codes used by the game controller
//   SCORE_W       : width of the per-side score counters
package rps_pkg;

    localparam int SCORE_W = 4;

    localparam logic [1:0] CHOICE_NONE     = 2'b00;
    localparam logic [1:0] CHOICE_ROCK     = 2'b01;
    localparam logic [1:0] CHOICE_PAPER    = 2'b10;
    localparam logic [1:0] CHOICE_SCISSORS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CHOICE,
        ST_LOCK,
        ST_SAMPLE,
        ST_RESULT,
        ST_MATCH_OVER
    } seq_state_t;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter shared by the choice window and the result hold.
//   clock, reset_button : system clock, synchronous active-high reset
//   load, load_value    : start a new interval of load_value cycles
//   expired             : high during the last cycle of the loaded interval
module round_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset_button,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset_button) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // The first cycle after a load sees load_value, so the interval's last
    // cycle is the one where the count has come down to 1.
    assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/round_sequencer.sv
// Match-level sequencer driving the game controller: starts rounds, waits for
// a player choice, locks the controller in, samples win/lose and keeps score.
//   clock, reset_button           : system clock, synchronous active-high reset
//   start_button                  : level input, rising edge starts a match
//   player_chosen                 : controller has a non-NONE player choice
//   win_led, lose_led             : controller round result
//   stop_signal                   : lock-in to the controller
//   round_reset                   : one-cycle pulse clearing the player choice
//   player_score, computer_score  : rounds won per side
//   tie_count                     : tied rounds, saturating
//   match_over, match_won         : match finished / player won it
//   protocol_error                : sticky, both LEDs seen high together
module round_sequencer
    import rps_pkg::*;
#(
    parameter int ROUNDS_TO_WIN  = 3,
    parameter int CHOICE_TIMEOUT = 1000,
    parameter int RESULT_HOLD    = 8
) (
    input  logic               clock,
    input  logic               reset_button,
    input  logic               start_button,
    input  logic               player_chosen,
    input  logic               win_led,
    input  logic               lose_led,
    output logic               stop_signal,
    output logic               round_reset,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] computer_score,
    output logic [7:0]         tie_count,
    output logic               match_over,
    output logic               match_won,
    output logic               protocol_error
);

    localparam int TIMER_MAX = (CHOICE_TIMEOUT > RESULT_HOLD) ? CHOICE_TIMEOUT : RESULT_HOLD;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [SCORE_W-1:0] WIN_SCORE   = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [TIMER_W-1:0] CHOICE_LOAD = TIMER_W'(CHOICE_TIMEOUT);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(RESULT_HOLD);

    seq_state_t         state_q, state_d;
    logic               start_q;
    logic               start_edge;
    logic [SCORE_W-1:0] player_d, computer_d;
    logic [7:0]         tie_d;
    logic               error_d, stop_d, round_reset_d, match_over_d, match_won_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;

    assign start_edge = start_button & ~start_q;

    round_timer #(.WIDTH(TIMER_W)) u_timer (
        .clock        (clock),
        .reset_button (reset_button),
        .load         (timer_load),
        .load_value   (timer_value),
        .expired      (timer_expired)
    );

    // All outputs are registered; the combinational block below only
    // computes their next values.
    always_ff @(posedge clock) begin
        // Tracking the button even in reset means a button held through
        // reset reads as "already pressed" and needs a release first.
        start_q <= start_button;
        if (reset_button) begin
            state_q        <= ST_IDLE;
            stop_signal    <= 1'b0;
            round_reset    <= 1'b0;
            player_score   <= '0;
            computer_score <= '0;
            tie_count      <= '0;
            match_over     <= 1'b0;
            match_won      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_signal    <= stop_d;
            round_reset    <= round_reset_d;
            player_score   <= player_d;
            computer_score <= computer_d;
            tie_count      <= tie_d;
            match_over     <= match_over_d;
            match_won      <= match_won_d;
            protocol_error <= error_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        player_d      = player_score;
        computer_d    = computer_score;
        tie_d         = tie_count;
        error_d       = protocol_error;
        stop_d        = stop_signal;
        round_reset_d = 1'b0;
        match_over_d  = match_over;
        match_won_d   = match_won;
        timer_load    = 1'b0;
        timer_value   = CHOICE_LOAD;

        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start_edge) begin
                    player_d      = '0;
                    computer_d    = '0;
                    tie_d         = '0;
                    error_d       = 1'b0;
                    stop_d        = 1'b0;
                    match_over_d  = 1'b0;
                    match_won_d   = 1'b0;
                    round_reset_d = 1'b1;
                    timer_load    = 1'b1;
                    timer_value   = CHOICE_LOAD;
                    state_d       = ST_WAIT_CHOICE;
                end
            end

            ST_WAIT_CHOICE: begin
                // A choice arriving in the expiry cycle still counts.
                if (player_chosen) begin
                    stop_d  = 1'b1;
                    state_d = ST_LOCK;
                end else if (timer_expired) begin
                    // Forfeit: nothing was chosen, so the controller is never
                    // locked and stop_signal stays low for the hold period.
                    if (computer_score != WIN_SCORE) begin
                        computer_d = computer_score + SCORE_W'(1);
                    end
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                    state_d     = ST_RESULT;
                end
            end

            // One full lock-in cycle lets the controller freeze its own choice
            // before the LEDs are trusted.
            ST_LOCK: state_d = ST_SAMPLE;

            ST_SAMPLE: begin
                case ({win_led, lose_led})
                    2'b10: if (player_score != WIN_SCORE) player_d = player_score + SCORE_W'(1);
                    2'b01: if (computer_score != WIN_SCORE) computer_d = computer_score + SCORE_W'(1);
                    default: begin
                        // Both LEDs together is illegal; score it as a tie.
                        if (tie_count != 8'hFF) tie_d = tie_count + 8'd1;
                        if (win_led) error_d = 1'b1;
                    end
                endcase
                timer_load  = 1'b1;
                timer_value = HOLD_LOAD;
                state_d     = ST_RESULT;
            end

            ST_RESULT: begin
                if (timer_expired) begin
                    if (player_score == WIN_SCORE || computer_score == WIN_SCORE) begin
                        stop_d       = 1'b1;
                        match_over_d = 1'b1;
                        match_won_d  = (player_score == WIN_SCORE);
                        state_d      = ST_MATCH_OVER;
                    end else begin
                        stop_d        = 1'b0;
                        round_reset_d = 1'b1;
                        timer_load    = 1'b1;
                        timer_value   = CHOICE_LOAD;
                        state_d       = ST_WAIT_CHOICE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a round-level reference model.
module tb_round_sequencer;

    localparam int R = 3;
    localparam int T = 5;
    localparam int H = 8;

    logic       clock = 1'b0;
    logic       reset_button, start_button, player_chosen, win_led, lose_led;
    logic       stop_signal, round_reset, match_over, match_won, protocol_error;
    logic [3:0] player_score, computer_score;
    logic [7:0] tie_count;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int rr_count = 0;
    int rr_base;

    // Reference model: tracks the round as "cycle k since the round began",
    // with the choice cycle remembered, and derives every event from that.
    int m_k = 0;        // 0: no round running (idle or match over)
    int m_lock_k = 0;   // round cycle in which the choice was seen
    bit m_forfeit = 0;
    bit m_start_prev = 0;
    int m_p = 0, m_c = 0, m_t = 0;
    bit m_err = 0, m_stop = 0, m_rr = 0, m_over = 0, m_won = 0;

    always #5 clock = ~clock;

    round_sequencer #(
        .ROUNDS_TO_WIN  (R),
        .CHOICE_TIMEOUT (T),
        .RESULT_HOLD    (H)
    ) dut (
        .clock          (clock),
        .reset_button   (reset_button),
        .start_button   (start_button),
        .player_chosen  (player_chosen),
        .win_led        (win_led),
        .lose_led       (lose_led),
        .stop_signal    (stop_signal),
        .round_reset    (round_reset),
        .player_score   (player_score),
        .computer_score (computer_score),
        .tie_count      (tie_count),
        .match_over     (match_over),
        .match_won      (match_won),
        .protocol_error (protocol_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: dut=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        int end_k;
        edge_seen    = start_button && !m_start_prev;
        m_start_prev = start_button;
        m_rr         = 1'b0;
        if (reset_button) begin
            m_k = 0; m_lock_k = 0; m_forfeit = 0;
            m_p = 0; m_c = 0; m_t = 0;
            m_err = 0; m_stop = 0; m_over = 0; m_won = 0;
        end else if (m_k == 0) begin
            if (edge_seen) begin
                m_p = 0; m_c = 0; m_t = 0;
                m_err = 0; m_stop = 0; m_over = 0; m_won = 0;
                m_rr = 1; m_k = 1; m_lock_k = 0; m_forfeit = 0;
            end
        end else if (m_lock_k == 0 && !m_forfeit) begin
            if (player_chosen) begin
                m_lock_k = m_k;
                m_stop   = 1;
            end else if (m_k == T) begin
                m_forfeit = 1;
                if (m_c < R) m_c++;
            end
            m_k++;
        end else begin
            if (!m_forfeit && m_k == m_lock_k + 2) begin
                if (win_led && !lose_led) begin
                    if (m_p < R) m_p++;
                end else if (lose_led && !win_led) begin
                    if (m_c < R) m_c++;
                end else begin
                    if (m_t < 255) m_t++;
                    if (win_led && lose_led) m_err = 1;
                end
            end
            end_k = m_forfeit ? (T + H) : (m_lock_k + 2 + H);
            if (m_k == end_k) begin
                if (m_p == R || m_c == R) begin
                    m_over = 1; m_won = (m_p == R); m_stop = 1; m_k = 0;
                end else begin
                    m_rr = 1; m_stop = 0; m_k = 1; m_lock_k = 0; m_forfeit = 0;
                end
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (round_reset === 1'b1) rr_count++;
        model_step();
        #1;
    endtask

    // Enter at the first WAIT cycle of a round; leave at the first cycle of
    // the next round (or of MATCH_OVER).
    task automatic play_round(input int wait_cycles, input bit w, input bit l);
        for (int i = 1; i < wait_cycles; i++) tick();
        player_chosen = 1'b1;
        tick();
        player_chosen = 1'b0;
        @(negedge clock);
        check("lock_latency_stop", stop_signal, 1);
        win_led  = w;
        lose_led = l;
        tick();
        tick();
        win_led  = 1'b0;
        lose_led = 1'b0;
        for (int i = 0; i < H; i++) tick();
    endtask

    task automatic play_forfeit();
        for (int i = 1; i < T; i++) tick();
        @(negedge clock);
        check("forfeit_before_timeout", computer_score, 0);
        tick();
        @(negedge clock);
        check("forfeit_score", computer_score, 1);
        check("forfeit_no_stop", stop_signal, 0);
        for (int i = 0; i < H; i++) tick();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (check_en) begin
            check("stop_signal", stop_signal, m_stop);
            check("round_reset", round_reset, m_rr);
            check("player_score", player_score, m_p);
            check("computer_score", computer_score, m_c);
            check("tie_count", tie_count, m_t);
            check("match_over", match_over, m_over);
            check("match_won", match_won, m_won);
            check("protocol_error", protocol_error, m_err);
        end
    end

    initial begin
        reset_button  = 1'b1;
        start_button  = 1'b0;
        player_chosen = 1'b0;
        win_led       = 1'b0;
        lose_led      = 1'b0;
        tick();
        tick();
        check_en = 1'b1;
        @(negedge clock);
        check("reset_stop", stop_signal, 0);
        check("reset_scores", {player_score, computer_score}, 0);
        check("reset_over", match_over, 0);
        reset_button = 1'b0;
        tick();

        // Match 1: player wins three straight rounds.
        rr_base      = rr_count;
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        @(negedge clock);
        check("m1_first_round_reset", round_reset, 1);
        check("m1_first_stop_low", stop_signal, 0);
        play_round(2, 1'b1, 1'b0);
        @(negedge clock);
        check("m1_player_after_r1", player_score, 1);
        check("m1_round_reset_r2", round_reset, 1);
        play_round(2, 1'b1, 1'b0);
        @(negedge clock);
        check("m1_player_after_r2", player_score, 2);
        play_round(2, 1'b1, 1'b0);
        @(negedge clock);
        check("m1_player_final", player_score, 3);
        check("m1_match_over", match_over, 1);
        check("m1_match_won", match_won, 1);
        check("m1_stop_held", stop_signal, 1);
        check("m1_round_reset_pulses", rr_count - rr_base, 3);
        tick();

        // Match 2: forfeit, win, ignored start, both-LED error, win, reset.
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        @(negedge clock);
        check("m2_scores_cleared", player_score, 0);
        check("m2_over_cleared", match_over, 0);
        play_forfeit();
        play_round(1, 1'b1, 1'b0);
        @(negedge clock);
        check("m2_player_1_1", player_score, 1);
        check("m2_computer_1_1", computer_score, 1);
        start_button = 1'b1;
        tick();
        start_button = 1'b0;
        @(negedge clock);
        check("m2_ignored_start_rr", round_reset, 0);
        check("m2_ignored_start_scores", {player_score, computer_score}, 8'h11);
        play_round(2, 1'b1, 1'b1);
        @(negedge clock);
        check("m2_protocol_error", protocol_error, 1);
        check("m2_both_tie", tie_count, 1);
        check("m2_both_scores", {player_score, computer_score}, 8'h11);
        play_round(1, 1'b1, 1'b0);
        @(negedge clock);
        check("m2_error_sticky", protocol_error, 1);
        check("m2_score_2_1", {player_score, computer_score}, 8'h21);
        player_chosen = 1'b1;
        tick();
        player_chosen = 1'b0;
        tick();
        tick();
        tick();
        tick();
        @(negedge clock);
        check("m2_in_result_stop", stop_signal, 1);
        check("m2_in_result_tie", tie_count, 2);
        reset_button = 1'b1;
        start_button = 1'b1;
        tick();
        @(negedge clock);
        check("rst_all_scores", {player_score, computer_score, tie_count}, 0);
        check("rst_flags", {stop_signal, round_reset, match_over, match_won, protocol_error}, 0);
        reset_button = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("held_start_no_restart", round_reset, 0);
        start_button = 1'b0;
        tick();
        start_button = 1'b1;
        tick();
        @(negedge clock);
        check("repress_restarts", round_reset, 1);
        start_button = 1'b0;

        // Match 3: tie then three losses.
        play_round(1, 1'b0, 1'b0);
        @(negedge clock);
        check("m3_tie", tie_count, 1);
        check("m3_tie_scores", {player_score, computer_score}, 0);
        play_round(3, 1'b0, 1'b1);
        @(negedge clock);
        check("m3_loss", computer_score, 1);
        play_round(1, 1'b0, 1'b1);
        play_round(2, 1'b0, 1'b1);
        @(negedge clock);
        check("m3_match_over", match_over, 1);
        check("m3_match_lost", match_won, 0);
        check("m3_computer_final", computer_score, 3);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
